pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload through STAGES register slices. Each slice has a valid bit and valid/ready back-pressure.
- Supports hazard-unit Stall and branch/exception Flush. Flush inserts bubbles by zeroing control bits, so a bubble behaves as a NOP downstream.
- One instance per pipeline boundary; it replaces the hand-written per-boundary registers.

Parameters:
- CTRL_W, 16: control-field width; zeroed on reset, flush and bubble.
- DATA_W, 128: datapath-field width; zeroed on reset only, otherwise held when a slice goes empty.
- STAGES, 1: number of chained slices, legal range 1..4. Values outside this range are an elaboration error.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  upstream presents a payload.
- InReady  out  1  this block accepts the payload this cycle.
- InCtrl  in  CTRL_W  control field.
- InData  in  DATA_W  datapath field.
- Stall  in  1  hazard hold: freezes every slice.
- Flush  in  1  squash: kills every slice and the current input.
- OutValid  out  1  last slice holds a live payload.
- OutReady  in  1  downstream accepts.
- OutCtrl  out  CTRL_W  last slice control field.
- OutData  out  DATA_W  last slice datapath field.
- Occupancy  out  $clog2(STAGES+2)  number of live entries, including the skid entry when enabled.

Behaviour:
- Reset (async, asserted): every valid=0, ctrl=0, data=0. Outputs: OutValid=0, OutCtrl=0, OutData=0, Occupancy=0, InReady=0. InReady becomes 1 on the first edge after release.
- Slice i advances when (not valid_i) or (slice i+1 advances). For the last slice, "slice i+1 advances" means OutReady & ~Stall.
- InReady = advance of slice 0 & ~Stall & ~Flush. The ready chain is combinational (no skid).
- Transfer rule: an input transfer is InValid & InReady; an output transfer is OutValid & OutReady.
- Advancing slice with no valid source: valid=0 and ctrl=0 (bubble); data is held.
- Stall=1: no slice changes; OutValid forced to 0; InReady=0.
- Flush=1: priority over Stall, InValid and OutReady. On the next edge all valid=0 and all ctrl=0. The input is not captured (InReady=0) and OutValid is forced to 0 in the same cycle.
- Latency: STAGES cycles from accept to OutValid with no Stall and no back-pressure. Throughput is 1 per cycle.
- Full pipeline with OutReady=0: InReady=0, contents held, no overwrite.
- Occupancy: +1 on an input transfer, -1 on an output transfer, net 0 when both occur together. Cleared by Flush and Reset. Never wraps; maximum is STAGES (STAGES+1 with skid).
- Reset mid-operation: everything clears asynchronously; any payload in flight is lost, with no partial state.

Optional Feature:
- Macro: PIPE_STAGE_REG_SKID_EN.
- When defined: a one-entry skid buffer sits ahead of slice 0, and InReady is driven from a flop (InReady = skid empty).
  - If slice 0 cannot advance, an accepted payload lands in the skid entry.
  - The skid entry drains first when slice 0 frees.
  - Flush clears the skid entry.
  - Latency is unchanged when the skid entry is empty.
- When undefined: combinational InReady as described above; no skid storage.

Decomposition:
- Package pipe_pkg:
  - STAGES_MAX=4 constant.
  - Occupancy-width function.
  - Typedef for the slice record {valid, ctrl, data}.
- Sub-module pipe_stage_cell: one slice with load/bubble/flush logic, instantiated STAGES times in a generate loop.

Test Plan:
1. STAGES=2, DATA_W=8, CTRL_W=4; push 0x11, 0x22, 0x33 on consecutive cycles with OutReady=1 -> OutData shows 0x11, 0x22, 0x33 on cycles 2, 3, 4; Occupancy peaks at 2.
2. Fill both slices, hold OutReady=0 for 5 cycles -> InReady=0, OutData stable at 0x11, Occupancy=2; release -> 0x11 then 0x22 drain in order.
3. Stall=1 for 3 cycles mid-stream -> OutValid=0, InReady=0, contents unchanged; after Stall=0 the stream resumes with no loss or duplication.
4. Flush with 2 live entries plus InValid=1 (ctrl=0xF) -> next cycle OutValid=0, OutCtrl=0, Occupancy=0; input not captured.
5. Assert Reset asynchronously between edges with a full pipeline -> outputs zero immediately, before the next edge; first post-reset input emerges after exactly STAGES cycles.
6. With PIPE_STAGE_REG_SKID_EN defined, OutReady=0 and pipe full, offer 0x44 -> accepted into skid, then InReady=0; Occupancy=3; drains 0x11, 0x22, 0x44 in order.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the parametrised inter-stage pipeline register.
package pipe_pkg;

    // Deepest chain a single boundary instance may build.
    localparam int STAGES_MAX = 4;

    // Occupancy counter width: room for every slice plus the optional skid entry.
    function automatic int occ_width(input int stages);
        return $clog2(stages + 2);
    endfunction

    // What a slice does on the coming edge.
    typedef enum logic [1:0] {
        SLICE_HOLD   = 2'd0,
        SLICE_LOAD   = 2'd1,
        SLICE_BUBBLE = 2'd2,
        SLICE_CLEAR  = 2'd3
    } slice_op_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle for one pipeline boundary.
//
// Handshake: an input transfer happens on a rising edge where InValid and
// InReady are both 1; an output transfer happens where OutValid and OutReady
// are both 1. Stall and Flush are side controls from the hazard unit.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int STAGES = 1
);
    localparam int OCC_W = pipe_pkg::occ_width(STAGES);

    logic              InValid;
    logic              InReady;
    logic [CTRL_W-1:0] InCtrl;
    logic [DATA_W-1:0] InData;
    logic              Stall;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [CTRL_W-1:0] OutCtrl;
    logic [DATA_W-1:0] OutData;
    logic [OCC_W-1:0]  Occupancy;

    // The pipeline register itself.
    modport slave (
        input  InValid, InCtrl, InData, Stall, Flush, OutReady,
        output InReady, OutValid, OutCtrl, OutData, Occupancy
    );

    // The surrounding stages and hazard unit.
    modport master (
        output InValid, InCtrl, InData, Stall, Flush, OutReady,
        input  InReady, OutValid, OutCtrl, OutData, Occupancy
    );
endinterface

// File: rtl/pipe_stage_reg_cell.sv
// One register slice: loads a payload, turns into a bubble, or is squashed.
// Control bits are zeroed whenever the slice goes empty; data is kept.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic              Flush,
    input  logic              SrcValid,
    input  logic [CTRL_W-1:0] SrcCtrl,
    input  logic [DATA_W-1:0] SrcData,
    output logic              Valid,
    output logic [CTRL_W-1:0] Ctrl,
    output logic [DATA_W-1:0] Data
);
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } slice_t;

    slice_t    slice_q;
    slice_op_e op;

    // Pick this edge's action; Flush outranks everything.
    always_comb begin
        op = SLICE_HOLD;
        if (Flush) begin
            op = SLICE_CLEAR;
        end else if (Load) begin
            op = SrcValid ? SLICE_LOAD : SLICE_BUBBLE;
        end
    end

    // Slice storage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slice_q <= '0;
        end else begin
            case (op)
                SLICE_LOAD: begin
                    slice_q.valid <= 1'b1;
                    slice_q.ctrl  <= SrcCtrl;
                    slice_q.data  <= SrcData;
                end
                SLICE_BUBBLE, SLICE_CLEAR: begin
                    slice_q.valid <= 1'b0;
                    slice_q.ctrl  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign Valid = slice_q.valid;
    assign Ctrl  = slice_q.ctrl;
    assign Data  = slice_q.data;
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES chained slices with
// valid/ready back-pressure, hazard Stall and branch/exception Flush.
// Optional feature macro: PIPE_STAGE_REG_SKID_EN (one-entry skid buffer ahead
// of slice 0, InReady driven from a flop).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int STAGES = 1
) (
    input logic              Clk,
    input logic              Reset,
    pipe_stage_reg_if.slave  bus
);
    localparam int OCC_W = occ_width(STAGES);

    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("pipe_stage_reg: STAGES must be in 1..4");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [CTRL_W-1:0] ctrl_a [STAGES];
    logic [DATA_W-1:0] data_a [STAGES];
    logic [STAGES-1:0] src_v;
    logic [CTRL_W-1:0] src_c [STAGES];
    logic [DATA_W-1:0] src_d [STAGES];
    logic              out_adv;
    logic              in_xfer;
    logic              out_xfer;
    logic              src0_valid;
    logic [CTRL_W-1:0] src0_ctrl;
    logic [DATA_W-1:0] src0_data;
    logic [OCC_W-1:0]  occ_q;

    assign out_adv = bus.OutReady & ~bus.Stall;

    // Ready chain from the output back: a slice may move if it or anything after it has a hole.
    always_comb begin
        logic a;
        a = out_adv;
        for (int i = STAGES - 1; i >= 0; i--) begin
            a      = a | ~vld[i];
            adv[i] = a;
        end
    end

    // Stall freezes every slice, even empty ones.
    assign load = adv & {STAGES{~bus.Stall}};

    assign bus.OutValid = vld[STAGES-1] & ~bus.Stall & ~bus.Flush;
    assign bus.OutCtrl  = ctrl_a[STAGES-1];
    assign bus.OutData  = data_a[STAGES-1];
    assign out_xfer     = bus.OutValid & bus.OutReady;
    assign in_xfer      = bus.InValid & bus.InReady;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_v;
    logic              in_ready_q;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign bus.InReady = in_ready_q & ~bus.Stall & ~bus.Flush;
    assign src0_valid  = skid_v | in_xfer;
    assign src0_ctrl   = skid_v ? skid_ctrl : bus.InCtrl;
    assign src0_data   = skid_v ? skid_data : bus.InData;

    // Skid entry: catches an accepted payload slice 0 cannot take, drains first.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            skid_v     <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b0;
        end else if (bus.Flush) begin
            skid_v     <= 1'b0;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b1;
        end else if (skid_v) begin
            if (load[0]) begin
                skid_v     <= 1'b0;
                skid_ctrl  <= '0;
                in_ready_q <= 1'b1;
            end
        end else begin
            in_ready_q <= 1'b1;
            if (in_xfer && !load[0]) begin
                skid_v     <= 1'b1;
                skid_ctrl  <= bus.InCtrl;
                skid_data  <= bus.InData;
                in_ready_q <= 1'b0;
            end
        end
    end
`else
    logic rst_done_q;

    // Keeps InReady low until the first edge after reset release.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rst_done_q <= 1'b0;
        else       rst_done_q <= 1'b1;
    end

    assign bus.InReady = rst_done_q & adv[0] & ~bus.Stall & ~bus.Flush;
    assign src0_valid  = in_xfer;
    assign src0_ctrl   = bus.InCtrl;
    assign src0_data   = bus.InData;
`endif

    // Each slice is fed by its predecessor; slice 0 by the input side.
    always_comb begin
        src_v[0] = src0_valid;
        src_c[0] = src0_ctrl;
        src_d[0] = src0_data;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = vld[i-1];
            src_c[i] = ctrl_a[i-1];
            src_d[i] = data_a[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        pipe_stage_cell #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_cell (
            .Clk      (Clk),
            .Reset    (Reset),
            .Load     (load[g]),
            .Flush    (bus.Flush),
            .SrcValid (src_v[g]),
            .SrcCtrl  (src_c[g]),
            .SrcData  (src_d[g]),
            .Valid    (vld[g]),
            .Ctrl     (ctrl_a[g]),
            .Data     (data_a[g])
        );
    end

    // Live-entry count follows the transfers on both ends.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            occ_q <= '0;
        end else if (bus.Flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign bus.Occupancy = occ_q;
endmodule
